// File: rtl/gcn_result_tx_if.sv
// Result-stream bus between the GCN result transmitter and its neighbours:
// start/column request, result-buffer read port and the framed 16-bit output word.
interface gcn_result_tx_if #(
   parameter int unsigned DW   = 16,
   parameter int unsigned AW   = 8,
   parameter int unsigned COLW = 8
);
   logic            i_start;
   logic [COLW-1:0] i_col1;
   logic [COLW-1:0] i_col2;
   logic            o_ren;
   logic [AW-1:0]   o_raddr;
   logic [DW-1:0]   i_rdata;
   logic            o_busy;
   logic            o_result;
   logic            o_done;
   logic            o_p0,  o_p1,  o_p2,  o_p3,  o_p4,  o_p5,  o_p6,  o_p7;
   logic            o_p8,  o_p9,  o_p10, o_p11, o_p12, o_p13, o_p14, o_p15;

   // Transmitter side
   modport master (
      input  i_start, i_col1, i_col2, i_rdata,
      output o_ren, o_raddr, o_busy, o_result, o_done,
      output o_p0, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7,
      output o_p8, o_p9, o_p10, o_p11, o_p12, o_p13, o_p14, o_p15
   );

   // Requester / buffer / pin side
   modport slave (
      output i_start, i_col1, i_col2, i_rdata,
      input  o_ren, o_raddr, o_busy, o_result, o_done,
      input  o_p0, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7,
      input  o_p8, o_p9, o_p10, o_p11, o_p12, o_p13, o_p14, o_p15
   );
endinterface

// File: rtl/gcn_result_tx.sv
// GCN result-stream transmitter. On a start request it latches two column indices,
// sends a header word {col2,col1}, then streams the N_NODES results of col1 followed
// by those of col2 out of a 1-cycle-latency result buffer. All outputs are registered.
// DW must be 16 (one bit per o_p pin) and 2*COLW must equal DW.
module gcn_result_tx #(
   parameter int unsigned N_NODES = 100,
   parameter int unsigned DW      = 16,
   parameter int unsigned AW      = 8,
   parameter int unsigned COLW    = 8
) (
   input logic             clk,
   input logic             rst,
   gcn_result_tx_if.master bus
);

   localparam int unsigned LastAddr = 2 * N_NODES - 1;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StStream,
      StDrain
   } state_t;

   state_t          state_q, state_d;
   logic            ren_q, ren_d;
   logic [AW-1:0]   raddr_q, raddr_d;
   // High when i_rdata carries the word for the address issued one edge earlier
   logic            rvalid_q, rvalid_d;
   logic            busy_q, busy_d;
   logic            result_q, result_d;
   logic [DW-1:0]   word_q, word_d;
   logic            done_q, done_d;
   logic [COLW-1:0] col1_q, col1_d;
   logic [COLW-1:0] col2_q, col2_d;
   logic            accept;

   // Next-state and registered-output computation
   always_comb begin
      state_d  = state_q;
      ren_d    = ren_q;
      raddr_d  = raddr_q;
      rvalid_d = ren_q;
      busy_d   = busy_q;
      result_d = result_q;
      word_d   = word_q;
      done_d   = 1'b0;
      col1_d   = col1_q;
      col2_d   = col2_q;
      accept   = 1'b0;

      unique case (state_q)
         StIdle: begin
            result_d = 1'b0;
            word_d   = '0;
            busy_d   = 1'b0;
            accept   = bus.i_start;
         end

         StFetch: begin
            // Header goes out while address 0 is being read
            word_d   = DW'({col2_q, col1_q});
            result_d = 1'b1;
            raddr_d  = AW'(1);
            state_d  = StStream;
         end

         StStream: begin
            if (rvalid_q) begin
               word_d = bus.i_rdata;
            end
            if (raddr_q == AW'(LastAddr)) begin
               // Last address was sampled by the buffer on this edge; hold raddr
               ren_d   = 1'b0;
               state_d = StDrain;
            end else begin
               raddr_d = raddr_q + AW'(1);
            end
         end

         StDrain: begin
            if (rvalid_q) begin
               word_d = bus.i_rdata;
            end else begin
               result_d = 1'b0;
               word_d   = '0;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = StIdle;
               // A start on the closing edge chains the next frame with one idle cycle
               accept   = bus.i_start;
            end
         end
      endcase

      if (accept) begin
         col1_d  = bus.i_col1;
         col2_d  = bus.i_col2;
         busy_d  = 1'b1;
         ren_d   = 1'b1;
         raddr_d = '0;
         state_d = StFetch;
      end
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         ren_q    <= 1'b0;
         raddr_q  <= '0;
         rvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         result_q <= 1'b0;
         word_q   <= '0;
         done_q   <= 1'b0;
         col1_q   <= '0;
         col2_q   <= '0;
      end else begin
         state_q  <= state_d;
         ren_q    <= ren_d;
         raddr_q  <= raddr_d;
         rvalid_q <= rvalid_d;
         busy_q   <= busy_d;
         result_q <= result_d;
         word_q   <= word_d;
         done_q   <= done_d;
         col1_q   <= col1_d;
         col2_q   <= col2_d;
      end
   end

   assign bus.o_ren    = ren_q;
   assign bus.o_raddr  = raddr_q;
   assign bus.o_busy   = busy_q;
   assign bus.o_result = result_q;
   assign bus.o_done   = done_q;
   assign bus.o_p0     = word_q[0];
   assign bus.o_p1     = word_q[1];
   assign bus.o_p2     = word_q[2];
   assign bus.o_p3     = word_q[3];
   assign bus.o_p4     = word_q[4];
   assign bus.o_p5     = word_q[5];
   assign bus.o_p6     = word_q[6];
   assign bus.o_p7     = word_q[7];
   assign bus.o_p8     = word_q[8];
   assign bus.o_p9     = word_q[9];
   assign bus.o_p10    = word_q[10];
   assign bus.o_p11    = word_q[11];
   assign bus.o_p12    = word_q[12];
   assign bus.o_p13    = word_q[13];
   assign bus.o_p14    = word_q[14];
   assign bus.o_p15    = word_q[15];

endmodule

// File: tb/tb_gcn_result_tx.sv
// Directed bench for gcn_result_tx: a 100-row instance for reset, nominal frame,
// busy guard, address sequence and mid-frame reset; a 4-row instance for back-to-back.
module tb_gcn_result_tx;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   gcn_result_tx_if #(.DW(16), .AW(8), .COLW(8)) bus_a ();
   gcn_result_tx_if #(.DW(16), .AW(8), .COLW(8)) bus_b ();

   gcn_result_tx #(.N_NODES(100), .DW(16), .AW(8), .COLW(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   gcn_result_tx #(.N_NODES(4), .DW(16), .AW(8), .COLW(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Result buffers: word at address a is 16'h1000 + a, one cycle read latency
   always @(posedge clk) begin
      if (bus_a.o_ren) bus_a.i_rdata <= 16'h1000 + {8'h00, bus_a.o_raddr};
      if (bus_b.o_ren) bus_b.i_rdata <= 16'h1000 + {8'h00, bus_b.o_raddr};
   end

   logic [15:0] p_a, p_b;
   logic [27:0] all_a;
   assign p_a = {bus_a.o_p15, bus_a.o_p14, bus_a.o_p13, bus_a.o_p12, bus_a.o_p11, bus_a.o_p10,
                 bus_a.o_p9, bus_a.o_p8, bus_a.o_p7, bus_a.o_p6, bus_a.o_p5, bus_a.o_p4,
                 bus_a.o_p3, bus_a.o_p2, bus_a.o_p1, bus_a.o_p0};
   assign p_b = {bus_b.o_p15, bus_b.o_p14, bus_b.o_p13, bus_b.o_p12, bus_b.o_p11, bus_b.o_p10,
                 bus_b.o_p9, bus_b.o_p8, bus_b.o_p7, bus_b.o_p6, bus_b.o_p5, bus_b.o_p4,
                 bus_b.o_p3, bus_b.o_p2, bus_b.o_p1, bus_b.o_p0};
   assign all_a = {bus_a.o_ren, bus_a.o_raddr, bus_a.o_busy, bus_a.o_result, p_a, bus_a.o_done};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start a frame on instance A and record it until a few cycles past o_done.
   // A second start with cols 7/9 is pulsed at cycle inject_at (negative: never).
   task automatic collect_a(input int inject_at,
                            output int n_words, output int n_bad_words,
                            output int n_reads, output int n_bad_reads,
                            output int n_done, output int n_runs, output int n_pnz,
                            output logic [15:0] header, output logic busy0,
                            output logic timed_out);
      int   after_done;
      logic prev_result;
      n_words = 0; n_bad_words = 0; n_reads = 0; n_bad_reads = 0;
      n_done = 0; n_runs = 0; n_pnz = 0; header = '0;
      after_done = -1; prev_result = 1'b0;
      @(negedge clk);
      bus_a.i_start = 1'b1; bus_a.i_col1 = 8'd3; bus_a.i_col2 = 8'd5;
      @(negedge clk);
      bus_a.i_start = 1'b0;
      busy0 = bus_a.o_busy;
      for (int cyc = 0; cyc < 450; cyc++) begin
         if (bus_a.o_ren) begin
            if (int'(bus_a.o_raddr) != n_reads) n_bad_reads++;
            n_reads++;
         end
         if (bus_a.o_result) begin
            if (!prev_result) n_runs++;
            if (n_words == 0) header = p_a;
            else if (p_a != 16'h1000 + 16'(n_words - 1)) n_bad_words++;
            n_words++;
         end else if (p_a != 16'h0000) begin
            n_pnz++;
         end
         prev_result = bus_a.o_result;
         if (bus_a.o_done) begin
            n_done++;
            if (after_done < 0) after_done = 0;
         end
         if (after_done >= 0) after_done++;
         if (cyc == inject_at) begin
            bus_a.i_start = 1'b1; bus_a.i_col1 = 8'd7; bus_a.i_col2 = 8'd9;
         end else if (cyc == inject_at + 1) begin
            bus_a.i_start = 1'b0;
         end
         if (after_done > 8) break;
         @(negedge clk);
      end
      bus_a.i_start = 1'b0;
      timed_out = (after_done < 0);
   endtask

   initial begin
      int          nw, nbw, nr, nbr, nd, nrun, npz, bad;
      logic [15:0] hdr;
      logic        busy0, tmo, done_seen;

      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      bus_a.i_start = 1'b0; bus_a.i_col1 = '0; bus_a.i_col2 = '0;
      bus_b.i_start = 1'b0; bus_b.i_col1 = '0; bus_b.i_col2 = '0;

      // Reset held for 2 cycles, then 10 quiet idle cycles
      repeat (2) @(negedge clk);
      check("reset_outputs", {4'h0, all_a}, 32'h0);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_quiet", {4'h0, all_a}, 32'h0);
      end

      // Nominal frame with full address monitoring
      collect_a(-1, nw, nbw, nr, nbr, nd, nrun, npz, hdr, busy0, tmo);
      check("nom_timeout", {31'h0, tmo}, 32'h0);
      check("nom_busy_start", {31'h0, busy0}, 32'h1);
      check("nom_header", {16'h0, hdr}, 32'h0503);
      check("nom_word_count", nw, 201);
      check("nom_word_values", nbw, 0);
      check("nom_contiguous", nrun, 1);
      check("nom_done_pulses", nd, 1);
      check("nom_p_zero_idle", npz, 0);
      check("addr_count", nr, 200);
      check("addr_order", nbr, 0);
      check("nom_busy_end", {31'h0, bus_a.o_busy}, 32'h0);
      check("nom_raddr_hold", {24'h0, bus_a.o_raddr}, 32'd199);

      // Busy guard: second start mid-frame must be ignored
      collect_a(60, nw, nbw, nr, nbr, nd, nrun, npz, hdr, busy0, tmo);
      check("guard_timeout", {31'h0, tmo}, 32'h0);
      check("guard_header", {16'h0, hdr}, 32'h0503);
      check("guard_word_count", nw, 201);
      check("guard_word_values", nbw, 0);
      check("guard_frames", nrun, 1);
      check("guard_done_pulses", nd, 1);
      check("guard_reads", nr, 200);

      // Back-to-back on the 4-row instance
      @(negedge clk);
      bus_b.i_start = 1'b1; bus_b.i_col1 = 8'd3; bus_b.i_col2 = 8'd5;
      @(negedge clk);
      bus_b.i_start = 1'b0;
      nw = 0; bad = 0;
      for (int cyc = 0; cyc < 40 && nw < 9; cyc++) begin
         if (bus_b.o_result) begin
            if (p_b != ((nw == 0) ? 16'h0503 : 16'h1000 + 16'(nw - 1))) bad++;
            nw++;
         end
         if (nw < 9) @(negedge clk);
      end
      check("b2b_first_words", nw, 9);
      check("b2b_first_values", bad, 0);
      // Start held across the edge that closes the frame and raises o_done
      bus_b.i_start = 1'b1; bus_b.i_col1 = 8'd1; bus_b.i_col2 = 8'd2;
      @(negedge clk);
      bus_b.i_start = 1'b0;
      check("b2b_gap", {30'h0, bus_b.o_done, bus_b.o_result}, 32'h2);
      @(negedge clk);
      check("b2b_header", {15'h0, bus_b.o_result, p_b}, 32'h1_0201);
      nw = 0; bad = 0; done_seen = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (bus_b.o_result) begin
            if (p_b != 16'h1000 + 16'(nw)) bad++;
            nw++;
         end
         if (bus_b.o_done) begin
            done_seen = 1'b1;
            break;
         end
      end
      check("b2b_second_words", nw, 8);
      check("b2b_second_values", bad, 0);
      check("b2b_second_done", {31'h0, done_seen}, 32'h1);

      // Mid-frame reset while col1 row 37 is on the pins
      @(negedge clk);
      bus_a.i_start = 1'b1; bus_a.i_col1 = 8'd3; bus_a.i_col2 = 8'd5;
      @(negedge clk);
      bus_a.i_start = 1'b0;
      for (int i = 0; i < 300 && !(bus_a.o_result && p_a == 16'h1025); i++) @(negedge clk);
      check("mid_row37_seen", {15'h0, bus_a.o_result, p_a}, 32'h1_1025);
      #1 rst = 1'b0;
      #1 check("mid_reset_async", {4'h0, all_a}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus_a.o_result || bus_a.o_ren || bus_a.o_busy) bad++;
      end
      check("mid_no_resume", bad, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
